// File: rtl/forth_pkg.sv
// Shared encodings for the Forth core emitter: command ops, instruction
// prefixes and the fixup-stack entry layout.
package forth_pkg;

    localparam int AW = 13;

    localparam logic [3:0] OP_LIT  = 4'd0;
    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_CALL = 4'd2;
    localparam logic [3:0] OP_JMP  = 4'd3;
    localparam logic [3:0] OP_JZ   = 4'd4;
    localparam logic [3:0] OP_RET  = 4'd5;
    localparam logic [3:0] OP_IF   = 4'd6;
    localparam logic [3:0] OP_ELSE = 4'd7;
    localparam logic [3:0] OP_THEN = 4'd8;
    localparam logic [3:0] OP_ORG  = 4'd9;

    localparam logic        PFX_IMM = 1'b1;
    localparam logic [2:0]  PFX_ALU = 3'b000;
    localparam logic [2:0]  PFX_J   = 3'b001;
    localparam logic [2:0]  PFX_JAL = 3'b010;
    localparam logic [2:0]  PFX_JZ  = 3'b011;
    localparam logic [15:0] INSN_JR = 16'h0000;

    typedef enum logic {
        FK_JZ  = 1'b0,
        FK_JMP = 1'b1
    } fix_kind_e;

    typedef struct packed {
        fix_kind_e      kind;
        logic [AW-1:0]  addr;
    } fix_t;

    function automatic logic [15:0] patch_word(fix_t e, logic [AW-1:0] tgt);
        return {(e.kind == FK_JMP) ? PFX_J : PFX_JZ, tgt};
    endfunction

endpackage

// File: rtl/prog_emitter_fixup_stack.sv
// LIFO of pending forward-branch fixups; a simultaneous pop+push
// replaces the top entry in place.
module fixup_stack
    import forth_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  fix_t                       din,
    output fix_t                       top,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    fix_t           mem [DEPTH];
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  tidx;
    logic [IW-1:0]  widx;
    logic           wr;

    assign tidx  = IW'(cnt - CW'(1));
    assign top   = mem[tidx];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    always_comb begin
        wr   = 1'b0;
        widx = cnt[IW-1:0];
        if (push && pop && !empty) begin
            wr   = 1'b1;
            widx = tidx;
        end else if (push && !pop && !full) begin
            wr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[widx] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !pop && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !push && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/prog_emitter.sv
// Compile-command emitter writing encoded Forth instructions to program RAM.
// ELSE support (two-write sequence) is built only with PROG_EMITTER_ELSE_EN.
module prog_emitter
    import forth_pkg::*;
#(
    parameter int FIX_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [3:0]                   cmd_op,
    input  logic [15:0]                  cmd_arg,
    output logic                         mem_we,
    output logic [12:0]                  mem_addr,
    output logic [15:0]                  mem_wdata,
    output logic [12:0]                  pc,
    output logic [$clog2(FIX_DEPTH):0]   depth,
    output logic [3:0]                   err
);

    logic          we_n;
    logic [12:0]   addr_n;
    logic [15:0]   data_n;
    logic [12:0]   pc_n;
    logic [3:0]    err_n;
    logic          emit;
    logic [15:0]   word;
    logic          hi_bad;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    fix_t          push_d;
    fix_t          top;

    fixup_stack #(.DEPTH(FIX_DEPTH)) u_fix (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_d),
        .top   (top),
        .full  (full),
        .empty (empty),
        .count (depth)
    );

    assign hi_bad = |cmd_arg[15:13];

`ifdef PROG_EMITTER_ELSE_EN
    typedef enum logic {IDLE, ELSE2} state_e;
    state_e        state, state_n;
    logic [12:0]   paddr, paddr_n;
    logic [15:0]   pdata, pdata_n;

    assign cmd_ready = (state == IDLE);
`else
    assign cmd_ready = 1'b1;
`endif

    always_comb begin
        we_n   = 1'b0;
        addr_n = mem_addr;
        data_n = mem_wdata;
        pc_n   = pc;
        err_n  = err;
        emit   = 1'b0;
        word   = '0;
        push   = 1'b0;
        pop    = 1'b0;
        push_d = '{kind: FK_JZ, addr: pc};
`ifdef PROG_EMITTER_ELSE_EN
        state_n = state;
        paddr_n = paddr;
        pdata_n = pdata;
        if (state == ELSE2) begin
            we_n    = 1'b1;
            addr_n  = paddr;
            data_n  = pdata;
            state_n = IDLE;
        end else
`endif
        if (cmd_valid && cmd_ready) begin
            unique case (1'b1)
                (cmd_op == OP_LIT): begin
                    if (cmd_arg[15]) err_n[0] = 1'b1;
                    else begin
                        emit = 1'b1;
                        word = {PFX_IMM, cmd_arg[14:0]};
                    end
                end
                // zero T-field bits would alias the return encoding
                (cmd_op == OP_ALU): begin
                    if (cmd_arg[12:9] == 4'd0) err_n[0] = 1'b1;
                    else begin
                        emit = 1'b1;
                        word = {PFX_ALU, cmd_arg[12:0]};
                    end
                end
                (cmd_op == OP_CALL),
                (cmd_op == OP_JMP),
                (cmd_op == OP_JZ): begin
                    if (hi_bad) err_n[0] = 1'b1;
                    else begin
                        emit = 1'b1;
                        word = {(cmd_op == OP_CALL) ? PFX_JAL :
                                (cmd_op == OP_JMP)  ? PFX_J : PFX_JZ,
                                cmd_arg[12:0]};
                    end
                end
                (cmd_op == OP_RET): begin
                    emit = 1'b1;
                    word = INSN_JR;
                end
                (cmd_op == OP_IF): begin
                    if (full) err_n[1] = 1'b1;
                    else begin
                        emit   = 1'b1;
                        word   = {PFX_JZ, 13'h0};
                        push   = 1'b1;
                        push_d = '{kind: FK_JZ, addr: pc};
                    end
                end
`ifdef PROG_EMITTER_ELSE_EN
                (cmd_op == OP_ELSE): begin
                    if (empty) err_n[2] = 1'b1;
                    else begin
                        emit    = 1'b1;
                        word    = {PFX_J, 13'h0};
                        pop     = 1'b1;
                        push    = 1'b1;
                        push_d  = '{kind: FK_JMP, addr: pc};
                        paddr_n = top.addr;
                        pdata_n = patch_word(top, pc + 13'd1);
                        state_n = ELSE2;
                    end
                end
`endif
                (cmd_op == OP_THEN): begin
                    if (empty) err_n[2] = 1'b1;
                    else begin
                        pop    = 1'b1;
                        we_n   = 1'b1;
                        addr_n = top.addr;
                        data_n = patch_word(top, pc);
                    end
                end
                (cmd_op == OP_ORG): begin
                    if (hi_bad) err_n[0] = 1'b1;
                    else pc_n = cmd_arg[12:0];
                end
                default: err_n[3] = 1'b1;
            endcase
            if (emit) begin
                we_n   = 1'b1;
                addr_n = pc;
                data_n = word;
                pc_n   = pc + 13'd1;
                if (pc == 13'h1FFF) err_n[3] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pc        <= '0;
            err       <= '0;
        end else begin
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= data_n;
            pc        <= pc_n;
            err       <= err_n;
        end
    end

`ifdef PROG_EMITTER_ELSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            paddr <= '0;
            pdata <= '0;
        end else begin
            state <= state_n;
            paddr <= paddr_n;
            pdata <= pdata_n;
        end
    end
`endif

endmodule

// File: tb/tb_prog_emitter.sv
// Directed bench for prog_emitter: write log captured on the falling edge
// and compared against hand-computed instruction words.
module tb_prog_emitter;

    localparam int FIX_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [15:0] cmd_arg = '0;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [12:0] pc;
    logic [3:0]  depth;
    logic [3:0]  err;

    int checks = 0;
    int errors = 0;
    int lowcnt = 0;
    int snap;
    logic [28:0] wq[$];

    prog_emitter #(.FIX_DEPTH(FIX_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .pc        (pc),
        .depth     (depth),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
        if (!rst && !cmd_ready) lowcnt++;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(logic [3:0] op, logic [15:0] arg);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_wr(string tag, logic [12:0] a, logic [15:0] d);
        logic [28:0] e;
        if (wq.size() == 0) begin
            chk(tag, 32'hFFFF_FFFF, {3'b0, a, d});
        end else begin
            e = wq.pop_front();
            chk(tag, {3'b0, e}, {3'b0, a, d});
        end
    endtask

    task automatic expect_none(string tag);
        chk(tag, wq.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_we"},    {31'd0, mem_we},    32'd0);
        chk({tag, "_addr"},  {19'd0, mem_addr},  32'd0);
        chk({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
        chk({tag, "_pc"},    {19'd0, pc},        32'd0);
        chk({tag, "_depth"}, {28'd0, depth},     32'd0);
        chk({tag, "_err"},   {28'd0, err},       32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;

        // basic encodings, back-to-back after the first
        send(4'd0, 16'h1234);
        @(negedge clk);
        chk("lit_lat_we",   {31'd0, mem_we},    32'd1);
        chk("lit_lat_addr", {19'd0, mem_addr},  32'd0);
        chk("lit_lat_data", {16'd0, mem_wdata}, 32'h9234);
        send(4'd1, 16'h0A85);
        send(4'd5, 16'h0000);
        chk("pc_after3", {19'd0, pc}, 32'd3);
        send(4'd4, 16'h0123);
        send(4'd3, 16'h1ABC);
        idle(3);
        expect_wr("w_lit", 13'h000, 16'h9234);
        expect_wr("w_alu", 13'h001, 16'h0A85);
        expect_wr("w_ret", 13'h002, 16'h0000);
        expect_wr("w_jz",  13'h003, 16'h6123);
        expect_wr("w_jmp", 13'h004, 16'h3ABC);
        expect_none("w_basic_end");
        chk("pc_after5", {19'd0, pc}, 32'd5);

        // IF / THEN
        send(4'd9, 16'h0010);
        send(4'd6, 16'h0000);
        chk("if_depth", {28'd0, depth}, 32'd1);
        send(4'd0, 16'h0005);
        send(4'd8, 16'h0000);
        chk("then_depth", {28'd0, depth}, 32'd0);
        idle(3);
        expect_wr("w_if",    13'h010, 16'h6000);
        expect_wr("w_lit5",  13'h011, 16'h8005);
        expect_wr("w_patch", 13'h010, 16'h6012);
        expect_none("w_ifthen_end");
        chk("ifthen_pc", {19'd0, pc}, 32'h12);

        // IF / ELSE / THEN
        snap = lowcnt;
        send(4'd9, 16'h0020);
        send(4'd6, 16'h0000);
        send(4'd0, 16'h0001);
`ifdef PROG_EMITTER_ELSE_EN
        send(4'd7, 16'h0000);
        send(4'd0, 16'h0002);
        send(4'd8, 16'h0000);
        idle(3);
        expect_wr("e_if",    13'h020, 16'h6000);
        expect_wr("e_lit1",  13'h021, 16'h8001);
        expect_wr("e_jmp",   13'h022, 16'h2000);
        expect_wr("e_patch", 13'h020, 16'h6023);
        expect_wr("e_lit2",  13'h023, 16'h8002);
        expect_wr("e_then",  13'h022, 16'h2024);
        expect_none("e_end");
        chk("e_pc",    {19'd0, pc},    32'h24);
        chk("e_depth", {28'd0, depth}, 32'd0);
        chk("e_ready_low", lowcnt - snap, 32'd1);
`else
        send(4'd8, 16'h0000);
        idle(3);
        expect_wr("e_if",   13'h020, 16'h6000);
        expect_wr("e_lit1", 13'h021, 16'h8001);
        expect_wr("e_then", 13'h020, 16'h6022);
        expect_none("e_end");
        chk("e_pc",        {19'd0, pc}, 32'h22);
        chk("e_ready_low", lowcnt - snap, 32'd0);
`endif

        // argument range and underflow errors
        send(4'd9, 16'h0030);
        send(4'd0, 16'h8000);
        send(4'd1, 16'h0085);
        send(4'd8, 16'h0000);
        send(4'd3, 16'h2000);
        idle(3);
        expect_none("err_nowrite");
        chk("err_bits", {28'd0, err}, 32'h5);
        chk("err_pc",   {19'd0, pc},  32'h30);

        // fixup overflow
        send(4'd9, 16'h0100);
        for (int i = 0; i <= FIX_DEPTH; i++) send(4'd6, 16'h0000);
        idle(3);
        for (int i = 0; i < FIX_DEPTH; i++)
            expect_wr("ovf_if", 13'(13'h100 + i), 16'h6000);
        expect_none("ovf_end");
        chk("ovf_err",   {28'd0, err},   32'h7);
        chk("ovf_depth", {28'd0, depth}, FIX_DEPTH);
        chk("ovf_pc",    {19'd0, pc},    32'h108);

        // pc wrap
        send(4'd9, 16'h1FFF);
        send(4'd2, 16'h0100);
        idle(3);
        expect_wr("wrap_call", 13'h1FFF, 16'h4100);
        expect_none("wrap_end");
        chk("wrap_pc",  {19'd0, pc},  32'd0);
        chk("wrap_err", {28'd0, err}, 32'hF);

        // reset while the ELSE patch is pending
        send(4'd7, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_else2");
        rst = 1'b0;
        idle(3);
`ifdef PROG_EMITTER_ELSE_EN
        expect_wr("rst_placeholder", 13'h000, 16'h2000);
`endif
        expect_none("rst_nopatch");

        // ELSE on an empty stack
        send(4'd7, 16'h0000);
        idle(2);
        expect_none("else_empty_nowrite");
`ifdef PROG_EMITTER_ELSE_EN
        chk("else_empty_err", {28'd0, err}, 32'h4);
`else
        chk("else_illegal_err", {28'd0, err}, 32'h8);
`endif

        // illegal op
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        send(4'hC, 16'h0000);
        idle(2);
        expect_none("illegal_nowrite");
        chk("illegal_err", {28'd0, err}, 32'h8);
        chk("illegal_pc",  {19'd0, pc},  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
